// File: rtl/hv_bundle_saturate.sv
// hv_bundle_saturate: clamped element-wise bundling of hypervectors in RAM.
// Define HV_BUNDLE_SAT_COUNT_EN to add the sat_count output and its counter.
module hv_bundle_saturate #(
  parameter int HYPERVECTOR_DIMENSIONS = 1000,
  parameter int NUM_OPERANDS = 3,
  parameter int CUT_NEG = -1,
  parameter int CUT_POS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [20:0] addr_src,
  input  logic [20:0] stride,
  input  logic [20:0] addr_dst,
  output logic        we_n,
  output logic [20:0] waddress,
  output logic [31:0] data_wr,
  output logic [20:0] raddress,
  input  logic [31:0] data_rd,
  output logic        busy,
  output logic        done
`ifdef HV_BUNDLE_SAT_COUNT_EN
  ,
  output logic [15:0] sat_count
`endif
);

  localparam int ACC_W = 32 + $clog2(NUM_OPERANDS);
  localparam int OP_W = $clog2(NUM_OPERANDS);
  localparam logic [OP_W-1:0] OP_LAST =
    OP_W'(NUM_OPERANDS - 1);
  localparam logic [15:0] EL_LAST =
    16'(HYPERVECTOR_DIMENSIONS - 1);
  localparam logic signed [ACC_W-1:0] LO =
    ACC_W'(CUT_NEG);
  localparam logic signed [ACC_W-1:0] HI =
    ACC_W'(CUT_POS);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [OP_W-1:0] op_cnt;
  logic [15:0] el_cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] rd_ext;
  logic signed [ACC_W-1:0] sum;
  logic lo_hit;
  logic hi_hit;
  logic [31:0] clip;

  logic [20:0] stride_q;
  logic [20:0] rd_ptr;
  logic [20:0] el_src;
  logic [20:0] dst_ptr;
  logic [20:0] raddress_q;
  logic [20:0] waddress_q;
  logic [31:0] data_wr_q;

  assign rd_ext = {{(ACC_W-32){data_rd[31]}}, data_rd};
  assign sum = acc + rd_ext;
  assign lo_hit = sum < LO;
  assign hi_hit = sum > HI;

  // clamp the full-width sum; the bounds always fit in 32 bits
  always_comb begin
    clip = sum[31:0];
    unique case (1'b1)
      lo_hit: clip = LO[31:0];
      hi_hit: clip = HI[31:0];
      default: clip = sum[31:0];
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end

  // next state and RAM-side outputs; idle ports replay last value
  always_comb begin
    state_nxt = state;
    we_n = 1'b1;
    busy = 1'b0;
    done = 1'b0;
    raddress = raddress_q;
    waddress = waddress_q;
    data_wr = data_wr_q;
    unique case (state)
      IDLE: begin
        if (valid) state_nxt = READ;
      end
      READ: begin
        busy = 1'b1;
        raddress = rd_ptr;
        if (op_cnt == OP_LAST) state_nxt = WRITE;
      end
      WRITE: begin
        busy = 1'b1;
        we_n = 1'b0;
        waddress = dst_ptr;
        data_wr = clip;
        if (el_cnt == EL_LAST) state_nxt = DONE;
        else state_nxt = READ;
      end
      DONE: begin
        done = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // address walk, operand accumulation and output hold registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_cnt <= '0;
      el_cnt <= '0;
      acc <= '0;
      stride_q <= '0;
      rd_ptr <= '0;
      el_src <= '0;
      dst_ptr <= '0;
      raddress_q <= '0;
      waddress_q <= '0;
      data_wr_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid) begin
            rd_ptr <= addr_src;
            el_src <= addr_src;
            dst_ptr <= addr_dst;
            stride_q <= stride;
            op_cnt <= '0;
            el_cnt <= '0;
            acc <= '0;
          end
        end
        READ: begin
          raddress_q <= rd_ptr;
          if (op_cnt != '0) acc <= sum;
          if (op_cnt == OP_LAST) begin
            op_cnt <= '0;
          end else begin
            op_cnt <= op_cnt + OP_W'(1);
            rd_ptr <= rd_ptr + stride_q;
          end
        end
        WRITE: begin
          waddress_q <= dst_ptr;
          data_wr_q <= clip;
          acc <= '0;
          el_src <= el_src + 21'd1;
          rd_ptr <= el_src + 21'd1;
          dst_ptr <= dst_ptr + 21'd1;
          el_cnt <= el_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef HV_BUNDLE_SAT_COUNT_EN
  // per-job count of clamped elements, sticks at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_count <= '0;
    end else if (state == IDLE && valid) begin
      sat_count <= '0;
    end else if (state == WRITE && (lo_hit || hi_hit)
                 && sat_count != 16'hFFFF) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hv_bundle_saturate.sv
// tb_hv_bundle_saturate: scoreboard bench for hv_bundle_saturate.
// Honors HV_BUNDLE_SAT_COUNT_EN for the sat_count checks.
module tb_hv_bundle_saturate;

  localparam int DIM1 = 8;
  localparam int DIM2 = 2;
  localparam int NOPS = 3;

  typedef struct packed {
    logic [20:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic reset;
  logic valid;
  logic valid2;
  logic [20:0] addr_src;
  logic [20:0] stride;
  logic [20:0] addr_dst;
  logic we_n, we_n2;
  logic [20:0] waddress, waddress2;
  logic [31:0] data_wr, data_wr2;
  logic [20:0] raddress, raddress2;
  logic [31:0] data_rd, data_rd2;
  logic busy, busy2;
  logic done, done2;
`ifdef HV_BUNDLE_SAT_COUNT_EN
  logic [15:0] sat_count, sat_count2;
`endif

  logic fill_we;
  logic [20:0] fill_addr;
  int fill_data;

  int mem [0:2097151];
  int cyc;
  int checks;
  int errors;
  wr_t q1[$];
  wr_t q2[$];
  wr_t mon_e;

  hv_bundle_saturate #(
    .HYPERVECTOR_DIMENSIONS(DIM1),
    .NUM_OPERANDS(NOPS),
    .CUT_NEG(-1),
    .CUT_POS(1)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .valid(valid),
    .addr_src(addr_src),
    .stride(stride),
    .addr_dst(addr_dst),
    .we_n(we_n),
    .waddress(waddress),
    .data_wr(data_wr),
    .raddress(raddress),
    .data_rd(data_rd),
    .busy(busy),
    .done(done)
`ifdef HV_BUNDLE_SAT_COUNT_EN
    ,
    .sat_count(sat_count)
`endif
  );

  hv_bundle_saturate #(
    .HYPERVECTOR_DIMENSIONS(DIM2),
    .NUM_OPERANDS(NOPS),
    .CUT_NEG(-100),
    .CUT_POS(100)
  ) u_dut2 (
    .clk(clk),
    .reset(reset),
    .valid(valid2),
    .addr_src(addr_src),
    .stride(stride),
    .addr_dst(addr_dst),
    .we_n(we_n2),
    .waddress(waddress2),
    .data_wr(data_wr2),
    .raddress(raddress2),
    .data_rd(data_rd2),
    .busy(busy2),
    .done(done2)
`ifdef HV_BUNDLE_SAT_COUNT_EN
    ,
    .sat_count(sat_count2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // shared RAM: bench fills, first DUT writes, both DUTs read
  always @(posedge clk) begin
    if (fill_we) mem[fill_addr] <= fill_data;
    if (we_n === 1'b0) mem[waddress] <= data_wr;
    data_rd <= mem[raddress];
    data_rd2 <= mem[raddress2];
  end

  task automatic fill(input logic [20:0] a, input int v);
    fill_we = 1'b1;
    fill_addr = a;
    fill_data = v;
    @(posedge clk);
    #1;
    fill_we = 1'b0;
  endtask

  task automatic push_job(input bit sel,
                          input logic [20:0] src,
                          input logic [20:0] str,
                          input logic [20:0] dst,
                          output int nsat);
    int pend [int];
    longint lo;
    longint hi;
    int dim;
    lo = sel ? -100 : -1;
    hi = sel ? 100 : 1;
    dim = sel ? DIM2 : DIM1;
    nsat = 0;
    for (int i = 0; i < dim; i++) begin
      longint s;
      logic [20:0] a;
      int v;
      wr_t e;
      s = 0;
      for (int k = 0; k < NOPS; k++) begin
        a = src + 21'(k) * str + 21'(i);
        if (pend.exists(int'(a))) v = pend[int'(a)];
        else v = mem[a];
        s += longint'(v);
      end
      if (s < lo) begin
        s = lo;
        nsat++;
      end else if (s > hi) begin
        s = hi;
        nsat++;
      end
      e.addr = dst + 21'(i);
      e.data = 32'(s);
      if (sel) q2.push_back(e);
      else begin
        pend[int'(e.addr)] = int'(e.data);
        q1.push_back(e);
      end
    end
  endtask

  task automatic start_job(input bit sel,
                           input logic [20:0] s,
                           input logic [20:0] st,
                           input logic [20:0] d,
                           output int t0);
    @(posedge clk);
    #1;
    if (sel) valid2 = 1'b1;
    else valid = 1'b1;
    addr_src = s;
    stride = st;
    addr_dst = d;
    @(posedge clk);
    #1;
    valid = 1'b0;
    valid2 = 1'b0;
    t0 = cyc;
    addr_src = 21'h0ABCDE;
    stride = 21'h012345;
    addr_dst = 21'h1F0F0F;
  endtask

  task automatic wait_done(input bit sel, output int dcyc,
                           output bit ok, output logic bsy);
    ok = 1'b0;
    dcyc = 0;
    bsy = 1'bx;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if ((sel ? done2 : done) === 1'b1) begin
        dcyc = cyc;
        ok = 1'b1;
        bsy = sel ? busy2 : busy;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (we_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got we_n=%b busy=%b done=%b need 1 0 0",
               we_n, busy, done);
    end
    checks++;
    if (waddress !== 21'd0 || raddress !== 21'd0 || data_wr !== 32'd0) begin
      errors++;
      $display("FAIL reset_data got wa=%h ra=%h wd=%h need zeros",
               waddress, raddress, data_wr);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b busy2=%b need 0 0", busy, busy2);
    end
  endtask

  task automatic test_saturate();
    int n, t0, td;
    bit ok;
    logic b;
    for (int i = 0; i < 8; i++) begin
      fill(21'(i), 25);
      fill(21'(1024 + i), 25);
      fill(21'(2048 + i), 25);
    end
    push_job(1'b0, 21'd0, 21'd1024, 21'd4096, n);
    start_job(1'b0, 21'd0, 21'd1024, 21'd4096, t0);
    wait_done(1'b0, td, ok, b);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sat_timeout got no done need done");
    end
    checks++;
    if (td - t0 !== 32) begin
      errors++;
      $display("FAIL sat_latency got %0d need 32", td - t0);
    end
    checks++;
    if (b !== 1'b0) begin
      errors++;
      $display("FAIL sat_busy_in_done got %b need 0", b);
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL sat_missing_writes got %0d left need 0", q1.size());
    end
    q1.delete();
`ifdef HV_BUNDLE_SAT_COUNT_EN
    @(negedge clk);
    checks++;
    if (sat_count !== 16'(n)) begin
      errors++;
      $display("FAIL sat_count got %0d need %0d", sat_count, n);
    end
`endif
  endtask

  task automatic test_zero_sum();
    int n, t0, td;
    bit ok;
    logic b;
    for (int i = 0; i < 8; i++) begin
      fill(21'(i), 5);
      fill(21'(1024 + i), -3);
      fill(21'(2048 + i), -2);
    end
    push_job(1'b0, 21'd0, 21'd1024, 21'd4096, n);
    start_job(1'b0, 21'd0, 21'd1024, 21'd4096, t0);
    wait_done(1'b0, td, ok, b);
    checks++;
    if (!ok || td - t0 !== 32) begin
      errors++;
      $display("FAIL zero_latency got ok=%0d len=%0d need 1 32", ok, td - t0);
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL zero_missing_writes got %0d left need 0", q1.size());
    end
    q1.delete();
`ifdef HV_BUNDLE_SAT_COUNT_EN
    checks++;
    if (sat_count !== 16'(n)) begin
      errors++;
      $display("FAIL zero_sat_count got %0d need %0d", sat_count, n);
    end
`endif
  endtask

  task automatic test_no_wrap();
    int n, t0, td;
    bit ok;
    logic b;
    for (int k = 0; k < NOPS; k++) begin
      for (int i = 0; i < 8; i++) begin
        fill(21'(300 + 8 * k + i),
             (i < 4) ? int'(32'h7FFFFFFF) : int'(32'h80000000));
      end
    end
    push_job(1'b0, 21'd300, 21'd8, 21'd5000, n);
    start_job(1'b0, 21'd300, 21'd8, 21'd5000, t0);
    wait_done(1'b0, td, ok, b);
    checks++;
    if (!ok || q1.size() != 0) begin
      errors++;
      $display("FAIL wide_sum_n1 got ok=%0d left=%0d need 1 0",
               ok, q1.size());
    end
    q1.delete();
    for (int a = 400; a < 406; a++) begin
      fill(21'(a), (a % 2 == 0) ? int'(32'h7FFFFFFF) : int'(32'h80000000));
    end
    push_job(1'b1, 21'd400, 21'd2, 21'd6000, n);
    start_job(1'b1, 21'd400, 21'd2, 21'd6000, t0);
    wait_done(1'b1, td, ok, b);
    checks++;
    if (!ok || td - t0 !== DIM2 * (NOPS + 1)) begin
      errors++;
      $display("FAIL wide_sum_latency got ok=%0d len=%0d need 1 %0d",
               ok, td - t0, DIM2 * (NOPS + 1));
    end
    checks++;
    if (q2.size() != 0) begin
      errors++;
      $display("FAIL wide_sum_cut100 got %0d left need 0", q2.size());
    end
    q2.delete();
  endtask

  task automatic test_addr_wrap();
    int n, t0, td;
    bit ok;
    logic b;
    logic [20:0] src;
    src = 21'h1FFFFE;
    for (int k = 0; k < NOPS; k++) begin
      for (int i = 0; i < 8; i++) begin
        fill(src + 21'(4 * k + i), int'($urandom_range(0, 4)) - 2);
      end
    end
    push_job(1'b0, src, 21'd4, 21'h1FFFF0, n);
    start_job(1'b0, src, 21'd4, 21'h1FFFF0, t0);
    wait_done(1'b0, td, ok, b);
    checks++;
    if (!ok || q1.size() != 0) begin
      errors++;
      $display("FAIL addr_wrap got ok=%0d left=%0d need 1 0", ok, q1.size());
    end
    q1.delete();
  endtask

  task automatic test_overlap();
    int n, t0, td;
    bit ok;
    logic b;
    for (int a = 200; a < 212; a++) begin
      fill(21'(a), int'($urandom_range(0, 4)) - 2);
    end
    push_job(1'b0, 21'd200, 21'd1, 21'd201, n);
    start_job(1'b0, 21'd200, 21'd1, 21'd201, t0);
    wait_done(1'b0, td, ok, b);
    checks++;
    if (!ok || q1.size() != 0) begin
      errors++;
      $display("FAIL overlap got ok=%0d left=%0d need 1 0", ok, q1.size());
    end
    q1.delete();
  endtask

  task automatic test_reset_mid_job();
    int n, t0, td, dcount;
    bit ok;
    logic b;
    for (int i = 0; i < 8; i++) begin
      fill(21'(i), 25);
      fill(21'(1024 + i), -25);
      fill(21'(2048 + i), 25);
    end
    push_job(1'b0, 21'd0, 21'd1024, 21'd4096, n);
    start_job(1'b0, 21'd0, 21'd1024, 21'd4096, t0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (we_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_ctrl got we_n=%b busy=%b need 1 0", we_n, busy);
    end
    checks++;
    if (waddress !== 21'd0 || raddress !== 21'd0 || data_wr !== 32'd0) begin
      errors++;
      $display("FAIL abort_data got wa=%h ra=%h wd=%h need zeros",
               waddress, raddress, data_wr);
    end
    checks++;
    if (q1.size() != 6) begin
      errors++;
      $display("FAIL abort_write_count got %0d left need 6", q1.size());
    end
    q1.delete();
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    checks++;
    if (dcount != 0) begin
      errors++;
      $display("FAIL abort_done got %0d pulses need 0", dcount);
    end
    push_job(1'b0, 21'd0, 21'd1024, 21'd4096, n);
    start_job(1'b0, 21'd0, 21'd1024, 21'd4096, t0);
    wait_done(1'b0, td, ok, b);
    checks++;
    if (!ok || td - t0 !== 32 || q1.size() != 0) begin
      errors++;
      $display("FAIL rerun got ok=%0d len=%0d left=%0d need 1 32 0",
               ok, td - t0, q1.size());
    end
    q1.delete();
  endtask

  task automatic test_back_to_back();
    int n, nd, d1, d2, extra;
    for (int i = 0; i < 8; i++) begin
      fill(21'(i), -7);
      fill(21'(1024 + i), 3);
      fill(21'(2048 + i), i);
    end
    push_job(1'b0, 21'd0, 21'd1024, 21'd4096, n);
    push_job(1'b0, 21'd0, 21'd1024, 21'd4096, n);
    @(posedge clk);
    #1;
    valid = 1'b1;
    addr_src = 21'd0;
    stride = 21'd1024;
    addr_dst = 21'd4096;
    nd = 0;
    d1 = 0;
    d2 = 0;
    for (int c = 0; c < 300 && nd < 2; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        nd++;
        if (nd == 1) d1 = cyc;
        else begin
          d2 = cyc;
          valid = 1'b0;
        end
      end
    end
    valid = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (nd != 2) begin
      errors++;
      $display("FAIL b2b_done_count got %0d need 2", nd);
    end
    checks++;
    if (d2 - d1 != 34) begin
      errors++;
      $display("FAIL b2b_gap got %0d need 34", d2 - d1);
    end
    checks++;
    if (extra != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL b2b_tail got extra=%0d left=%0d need 0 0",
               extra, q1.size());
    end
    q1.delete();
  endtask

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    valid = 1'b0;
    valid2 = 1'b0;
    addr_src = '0;
    stride = '0;
    addr_dst = '0;
    fill_we = 1'b0;
    fill_addr = '0;
    fill_data = 0;
    fork
      forever begin
        @(negedge clk);
        if (we_n === 1'b0) begin
          checks++;
          if (q1.size() == 0) begin
            errors++;
            $display("FAIL sb1_extra got wa=%h wd=%h need no write",
                     waddress, data_wr);
          end else begin
            mon_e = q1.pop_front();
            if (waddress !== mon_e.addr || data_wr !== mon_e.data) begin
              errors++;
              $display("FAIL sb1_write got wa=%h wd=%h need wa=%h wd=%h",
                       waddress, data_wr, mon_e.addr, mon_e.data);
            end
          end
        end
        if (we_n2 === 1'b0) begin
          checks++;
          if (q2.size() == 0) begin
            errors++;
            $display("FAIL sb2_extra got wa=%h wd=%h need no write",
                     waddress2, data_wr2);
          end else begin
            mon_e = q2.pop_front();
            if (waddress2 !== mon_e.addr || data_wr2 !== mon_e.data) begin
              errors++;
              $display("FAIL sb2_write got wa=%h wd=%h need wa=%h wd=%h",
                       waddress2, data_wr2, mon_e.addr, mon_e.data);
            end
          end
        end
      end
    join_none
    test_reset();
    test_saturate();
    test_zero_sum();
    test_no_wrap();
    test_addr_wrap();
    test_overlap();
    test_reset_mid_job();
    test_back_to_back();
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
